// File: rtl/shared_mem_pkg.sv
// Shared definitions for the PE-side shared-memory master: FSM states,
// default sizing and the address legality check.
package shared_mem_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int MEM_WORDS_DEF = 256;
  localparam int ERR_CNT_W_DEF = 8;
  localparam logic [ERR_CNT_W_DEF-1:0] ERR_CNT_SAT = '1;

  // Legal means word aligned and the word index falls inside the memory.
  function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] words);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < words);
  endfunction

endpackage

// File: rtl/shared_mem_master.sv
// Single-outstanding load/store initiator for the shared-memory port.
// Requests are range/alignment checked; illegal ones answer with rsp_err without touching memory.
module shared_mem_master
  import shared_mem_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int DATA_W    = 32,
  parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [31:0]          req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic [31:0]          mem_address,
  output logic [DATA_W-1:0]    mem_write_data,
  output logic                 mem_read,
  output logic                 mem_write,
  input  logic [DATA_W-1:0]    mem_read_data,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  state_t state, state_nxt;
  logic   wr_q;
  logic   accept;
  logic   legal;

  always_comb begin
    req_ready = (state == IDLE) && !rst;
    accept    = req_valid && req_ready;
    legal     = addr_legal(req_addr, 32'(MEM_WORDS));
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = legal ? ISSUE : RESP;
      ISSUE:   state_nxt = wr_q ? RESP : WAIT;
      WAIT:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes and rsp_valid are registered from the next state so they are
  // clean flops and drop in the same edge that resets the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wr_q           <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_rdata      <= '0;
      err_count      <= '0;
    end else begin
      state     <= state_nxt;
      mem_read  <= accept && legal && !req_write;
      mem_write <= accept && legal && req_write;
      rsp_valid <= (state_nxt == RESP);
      if (accept) begin
        wr_q      <= req_write;
        rsp_err   <= !legal;
        rsp_rdata <= '0;
        if (legal) begin
          mem_address    <= {2'b00, req_addr[31:2]};
          mem_write_data <= req_wdata;
        end else if (err_count != ERR_MAX) begin
          err_count <= err_count + 1'b1;
        end
      end
      if (state == WAIT) rsp_rdata <= mem_read_data;
    end
  end

endmodule
